// File: rtl/fdtd_step_sequencer.sv
// Autonomous multi-step FDTD sequencer: Hy update, Ez update, source injection per step,
// with per-phase valid/address delay lines that align buffer writes to datapath latency.

// Fixed-length valid+address delay line; address is zeroed when not valid.
module fdtd_pipe_delay #(
  parameter int LEN = 3,
  parameter int AW  = 6
) (
  input  logic          clk,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);
  logic [LEN-1:0] valid;
  logic [AW-1:0]  addr [LEN];

  always_ff @(posedge clk) begin
    if (flush) begin
      valid <= '0;
      for (int i = 0; i < LEN; i++) addr[i] <= '0;
    end else begin
      valid[0] <= in_valid;
      addr[0]  <= in_valid ? in_addr : '0;
      for (int i = 1; i < LEN; i++) begin
        valid[i] <= valid[i-1];
        addr[i]  <= addr[i-1];
      end
    end
  end

  assign out_valid = valid[LEN-1];
  assign out_addr  = addr[LEN-1];
endmodule

// Handshake: start_i is a request sampled only in IDLE; busy_o is high from the cycle after
// acceptance through the DONE cycle, where done_o pulses once. abort_i/RST cut a run short.
module fdtd_step_sequencer #(
  parameter int ADDR_WIDTH   = 6,
  parameter int STEP_WIDTH   = 16,
  parameter int HY_PIPE_LEN  = 3,
  parameter int EZ_PIPE_LEN  = 3,
  parameter int SRC_PIPE_LEN = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH:0]   cells_i,
  input  logic [STEP_WIDTH-1:0] steps_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [STEP_WIDTH-1:0] step_cnt_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  calc_hy_en_o,
  output logic                  calc_ez_en_o,
  output logic                  calc_src_en_o,
  output logic                  wrt_hy_en_o,
  output logic                  wrt_ez_en_o,
  output logic [ADDR_WIDTH-1:0] wrt_addr_o,
  output logic [2:0]            dbg_state
);
  typedef enum logic [2:0] {
    IDLE, HY_RUN, HY_DRAIN, EZ_RUN, EZ_DRAIN, SRC_RUN, SRC_DRAIN, DONE
  } state_t;

  localparam int CNT_W = (ADDR_WIDTH + 1 > 8) ? ADDR_WIDTH + 1 : 8;
  localparam logic [ADDR_WIDTH:0] MAX_CELLS = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] HY_LAST  = CNT_W'(HY_PIPE_LEN - 1);
  localparam logic [CNT_W-1:0] EZ_LAST  = CNT_W'(EZ_PIPE_LEN - 1);
  localparam logic [CNT_W-1:0] SRC_LAST = CNT_W'(SRC_PIPE_LEN - 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH:0]   cells_q;
  logic [STEP_WIDTH-1:0] steps_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [STEP_WIDTH-1:0] step_cnt;
  logic                  abort_take, run_last, src_ok, step_end;
  logic                  hy_wv, ez_wv, src_wv;
  logic [ADDR_WIDTH-1:0] hy_wa, ez_wa, src_wa;

  assign abort_take = abort_i && (state != IDLE);
  assign run_last   = (cnt == (CNT_W'(cells_q) - CNT_W'(1)));
  assign src_ok     = ({1'b0, src_q} < cells_q);
  assign step_end   = (state == SRC_DRAIN) && (cnt == SRC_LAST);

  always_comb begin
    state_next = state;
    if (abort_take) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      if (start_i) state_next = (cells_i == '0 || steps_i == '0) ? DONE : HY_RUN;
        HY_RUN:    if (run_last) state_next = HY_DRAIN;
        HY_DRAIN:  if (cnt == HY_LAST) state_next = EZ_RUN;
        EZ_RUN:    if (run_last) state_next = EZ_DRAIN;
        EZ_DRAIN:  if (cnt == EZ_LAST) state_next = SRC_RUN;
        SRC_RUN:   state_next = SRC_DRAIN;
        SRC_DRAIN: if (step_end)
                     state_next = ((step_cnt + STEP_WIDTH'(1)) == steps_q) ? DONE : HY_RUN;
        DONE:      state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      cells_q  <= '0;
      steps_q  <= '0;
      src_q    <= '0;
      step_cnt <= '0;
    end else begin
      state <= state_next;
      // cnt counts cycles spent in the current state
      cnt   <= (state_next != state || state == IDLE) ? '0 : cnt + CNT_W'(1);
      if (state == IDLE && start_i) begin
        cells_q  <= (cells_i > MAX_CELLS) ? MAX_CELLS : cells_i;
        steps_q  <= steps_i;
        src_q    <= src_addr_i;
        step_cnt <= '0;
      end
      if (step_end && !abort_take) step_cnt <= step_cnt + STEP_WIDTH'(1);
    end
  end

  always_comb begin
    busy_o        = (state != IDLE);
    done_o        = (state == DONE);
    calc_hy_en_o  = (state == HY_RUN);
    calc_ez_en_o  = (state == EZ_RUN);
    calc_src_en_o = (state == SRC_RUN) && src_ok;
    rd_en_o       = calc_hy_en_o || calc_ez_en_o || calc_src_en_o;
    rd_addr_o     = '0;
    if (calc_hy_en_o || calc_ez_en_o) rd_addr_o = cnt[ADDR_WIDTH-1:0];
    else if (calc_src_en_o)           rd_addr_o = src_q;
  end

  fdtd_pipe_delay #(.LEN(HY_PIPE_LEN), .AW(ADDR_WIDTH)) u_hy_dly (
    .clk(CLK), .flush(RST || abort_take), .in_valid(calc_hy_en_o), .in_addr(rd_addr_o),
    .out_valid(hy_wv), .out_addr(hy_wa)
  );
  fdtd_pipe_delay #(.LEN(EZ_PIPE_LEN), .AW(ADDR_WIDTH)) u_ez_dly (
    .clk(CLK), .flush(RST || abort_take), .in_valid(calc_ez_en_o), .in_addr(rd_addr_o),
    .out_valid(ez_wv), .out_addr(ez_wa)
  );
  fdtd_pipe_delay #(.LEN(SRC_PIPE_LEN), .AW(ADDR_WIDTH)) u_src_dly (
    .clk(CLK), .flush(RST || abort_take), .in_valid(calc_src_en_o), .in_addr(rd_addr_o),
    .out_valid(src_wv), .out_addr(src_wa)
  );

  // Phases never overlap and idle lines carry zero addresses, so OR-merging is safe.
  assign wrt_hy_en_o = hy_wv;
  assign wrt_ez_en_o = ez_wv || src_wv;
  assign wrt_addr_o  = hy_wa | ez_wa | src_wa;
  assign step_cnt_o  = step_cnt;
  assign dbg_state   = state;
endmodule

// File: tb/tb_fdtd_step_sequencer.sv
// Directed bench for fdtd_step_sequencer: table of job vectors checked cycle by cycle
// against a frame-timing model, plus abort and mid-run reset sequences.
module tb_fdtd_step_sequencer;
  localparam int AW = 6;
  localparam int SW = 16;
  localparam int HP = 3;
  localparam int EP = 3;
  localparam int SP = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [AW:0]   cells_i = '0;
  logic [SW-1:0] steps_i = '0;
  logic [AW-1:0] src_addr_i = '0;
  logic          busy_o, done_o, rd_en_o, calc_hy_en_o, calc_ez_en_o, calc_src_en_o;
  logic          wrt_hy_en_o, wrt_ez_en_o;
  logic [SW-1:0] step_cnt_o;
  logic [AW-1:0] rd_addr_o, wrt_addr_o;
  logic [2:0]    dbg_state;

  fdtd_step_sequencer #(
    .ADDR_WIDTH(AW), .STEP_WIDTH(SW), .HY_PIPE_LEN(HP), .EZ_PIPE_LEN(EP), .SRC_PIPE_LEN(SP)
  ) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .abort_i(abort_i), .cells_i(cells_i),
    .steps_i(steps_i), .src_addr_i(src_addr_i), .busy_o(busy_o), .done_o(done_o),
    .step_cnt_o(step_cnt_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .calc_hy_en_o(calc_hy_en_o), .calc_ez_en_o(calc_ez_en_o), .calc_src_en_o(calc_src_en_o),
    .wrt_hy_en_o(wrt_hy_en_o), .wrt_ez_en_o(wrt_ez_en_o), .wrt_addr_o(wrt_addr_o),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [SW-1:0] step_cnt;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          calc_hy;
    logic          calc_ez;
    logic          calc_src;
    logic          wrt_hy;
    logic          wrt_ez;
    logic [AW-1:0] wrt_addr;
  } out_t;

  typedef struct {
    logic [AW:0]   cells;
    logic [SW-1:0] steps;
    logic [AW-1:0] src;
    bit            hold;
    int            exp_busy;
    logic [SW-1:0] exp_final;
  } vec_t;

  out_t act;
  assign act = {busy_o, done_o, step_cnt_o, rd_en_o, rd_addr_o, calc_hy_en_o, calc_ez_en_o,
                calc_src_en_o, wrt_hy_en_o, wrt_ez_en_o, wrt_addr_o};

  int tests = 0;
  int fails = 0;

  function automatic int clampc(input logic [AW:0] cells);
    return (int'(cells) > 64) ? 64 : int'(cells);
  endfunction

  function automatic int total_of(input logic [AW:0] cells, input logic [SW-1:0] steps);
    int c = clampc(cells);
    int f = 2 * c + HP + EP + 1 + SP;
    return (c == 0 || steps == 0) ? 1 : int'(steps) * f + 1;
  endfunction

  // Expected outputs in busy cycle k (k=1 is the cycle after the start edge).
  function automatic out_t model(input logic [AW:0] cells, input logic [SW-1:0] steps,
                                 input logic [AW-1:0] src, input int k);
    out_t o = '0;
    int c = clampc(cells);
    int f = 2 * c + HP + EP + 1 + SP;
    int total = total_of(cells, steps);
    int j, s;
    bit sok = (int'(src) < c);
    if (k >= total) begin
      o.step_cnt = (total == 1) ? '0 : steps;
      o.busy     = (k == total);
      o.done     = (k == total);
      return o;
    end
    o.busy = 1'b1;
    j = (k - 1) % f;
    s = (k - 1) / f;
    o.step_cnt = SW'(s);
    if (j < c) begin
      o.rd_en = 1'b1; o.calc_hy = 1'b1; o.rd_addr = AW'(j);
    end else if (j >= c + HP && j < 2 * c + HP) begin
      o.rd_en = 1'b1; o.calc_ez = 1'b1; o.rd_addr = AW'(j - c - HP);
    end else if (j == 2 * c + HP + EP && sok) begin
      o.rd_en = 1'b1; o.calc_src = 1'b1; o.rd_addr = src;
    end
    if (j >= HP && j < c + HP) begin
      o.wrt_hy = 1'b1; o.wrt_addr = AW'(j - HP);
    end else if (j >= c + HP + EP && j < 2 * c + HP + EP) begin
      o.wrt_ez = 1'b1; o.wrt_addr = AW'(j - c - HP - EP);
    end else if (j == f - 1 && sok) begin
      o.wrt_ez = 1'b1; o.wrt_addr = src;
    end
    return o;
  endfunction

  task automatic check(input string name, input int k, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic check_idle_state(input string name);
    tests++;
    if (dbg_state !== 3'd0) begin
      fails++;
      $display("FAIL %s state: got %0d expected 0", name, dbg_state);
    end
  endtask

  // Start a job and check every cycle up to stop_k (0 = through the idle cycle after DONE).
  task automatic run_job(input string name, input logic [AW:0] cells, input logic [SW-1:0] steps,
                         input logic [AW-1:0] src, input bit hold, input bit with_abort,
                         input int stop_k, output int busy_n, output logic [SW-1:0] final_cnt);
    int total = total_of(cells, steps);
    int last = (stop_k > 0) ? stop_k : total + 1;
    busy_n = 0;
    final_cnt = '0;
    @(negedge CLK);
    cells_i = cells; steps_i = steps; src_addr_i = src;
    start_i = 1'b1; abort_i = with_abort;
    @(posedge CLK);
    #1;
    abort_i = 1'b0;
    if (!hold) start_i = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge CLK);
      check(name, k, model(cells, steps, src, k));
      if (busy_o) busy_n++;
      if (k == total + 1) final_cnt = step_cnt_o;
      if (k >= total) start_i = 1'b0;
    end
  endtask

  vec_t vecs[10];
  out_t zero_o;
  out_t hold_o;
  int busy_n;
  logic [SW-1:0] fin;

  initial begin
    vecs[0] = '{7'd4,   16'd1, 6'd1,  1'b0, 18,  16'd1};
    vecs[1] = '{7'd4,   16'd3, 6'd2,  1'b1, 52,  16'd3};
    vecs[2] = '{7'd0,   16'd5, 6'd0,  1'b1, 1,   16'd0};
    vecs[3] = '{7'd4,   16'd0, 6'd0,  1'b1, 1,   16'd0};
    vecs[4] = '{7'd64,  16'd1, 6'd63, 1'b0, 138, 16'd1};
    vecs[5] = '{7'd100, 16'd1, 6'd10, 1'b0, 138, 16'd1};
    vecs[6] = '{7'd4,   16'd1, 6'd5,  1'b0, 18,  16'd1};
    vecs[7] = '{7'd1,   16'd2, 6'd0,  1'b0, 23,  16'd2};
    vecs[8] = '{7'd4,   16'd1, 6'd4,  1'b0, 18,  16'd1};
    vecs[9] = '{7'd65,  16'd2, 6'd0,  1'b0, 275, 16'd2};
    zero_o = '0;

    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset", 0, zero_o);
    check_idle_state("reset");
    RST = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].cells, vecs[i].steps, vecs[i].src,
              vecs[i].hold, 1'b0, 0, busy_n, fin);
      tests++;
      if (busy_n != vecs[i].exp_busy) begin
        fails++;
        $display("FAIL vec%0d busy_len: got %0d expected %0d", i, busy_n, vecs[i].exp_busy);
      end
      tests++;
      if (fin !== vecs[i].exp_final) begin
        fails++;
        $display("FAIL vec%0d final_cnt: got %0d expected %0d", i, fin, vecs[i].exp_final);
      end
    end

    // Abort in the second HY_DRAIN cycle: Hy address 3 must never be written.
    run_job("abort_pre", 7'd4, 16'd1, 6'd1, 1'b0, 1'b0, 6, busy_n, fin);
    abort_i = 1'b1;
    @(posedge CLK);
    #1 abort_i = 1'b0;
    for (int k = 7; k <= 10; k++) begin
      @(negedge CLK);
      check("abort_post", k, zero_o);
    end
    check_idle_state("abort_post");

    // Start and abort together in IDLE: the start wins and the job runs cleanly.
    run_job("start_abort", 7'd4, 16'd1, 6'd1, 1'b0, 1'b1, 0, busy_n, fin);

    // Abort after one completed step: step count holds at 1.
    run_job("abort_hold_pre", 7'd4, 16'd3, 6'd1, 1'b0, 1'b0, 20, busy_n, fin);
    abort_i = 1'b1;
    @(posedge CLK);
    #1 abort_i = 1'b0;
    hold_o = '0;
    hold_o.step_cnt = 16'd1;
    for (int k = 21; k <= 22; k++) begin
      @(negedge CLK);
      check("abort_hold_post", k, hold_o);
    end

    // Reset during the second step's EZ_RUN clears everything including the step count.
    run_job("rst_pre", 7'd4, 16'd2, 6'd1, 1'b0, 1'b0, 26, busy_n, fin);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("rst_mid", 27, zero_o);
    check_idle_state("rst_mid");
    RST = 1'b0;
    @(negedge CLK);
    check("rst_after", 28, zero_o);

    run_job("post_rst", 7'd2, 16'd1, 6'd0, 1'b0, 1'b0, 0, busy_n, fin);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
